// File: rtl/simple_calculator_pkg.sv
// Shared definitions for the simple_calculator datapath: default widths and
// the ALU opcode map used by Ctrl.
// Optional feature macro: SIMPLE_CALC_OVERFLOW_EN (adds a signed-overflow flag).
package simple_calculator_pkg;

    // Datapath and register-address width defaults.
    localparam int unsigned DEFAULT_DATA_W = 8;
    localparam int unsigned DEFAULT_ADDR_W = 3;
    localparam int unsigned CTRL_W         = 4;

    // ALU opcodes; codes 1101..1111 are unassigned and produce zero.
    localparam logic [CTRL_W-1:0] OP_ADD = 4'b0000;
    localparam logic [CTRL_W-1:0] OP_SUB = 4'b0001;
    localparam logic [CTRL_W-1:0] OP_AND = 4'b0010;
    localparam logic [CTRL_W-1:0] OP_OR  = 4'b0011;
    localparam logic [CTRL_W-1:0] OP_NOT = 4'b0100;
    localparam logic [CTRL_W-1:0] OP_XOR = 4'b0101;
    localparam logic [CTRL_W-1:0] OP_NOR = 4'b0110;
    localparam logic [CTRL_W-1:0] OP_SLL = 4'b0111;
    localparam logic [CTRL_W-1:0] OP_SRL = 4'b1000;
    localparam logic [CTRL_W-1:0] OP_SRA = 4'b1001;
    localparam logic [CTRL_W-1:0] OP_ROL = 4'b1010;
    localparam logic [CTRL_W-1:0] OP_ROR = 4'b1011;
    localparam logic [CTRL_W-1:0] OP_EQ  = 4'b1100;

    // True for the opcodes that drive the carry (and overflow) flags.
    function automatic logic is_arith(input logic [CTRL_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/calc_alu.sv
// Purely combinational ALU for simple_calculator: x is the RX operand, y the
// RY operand. Carry is meaningful only for add/subtract.
// Optional feature macro: SIMPLE_CALC_OVERFLOW_EN (adds the overflow output).
module calc_alu
    import simple_calculator_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] out,
`ifdef SIMPLE_CALC_OVERFLOW_EN
    output logic              carry,
    output logic              overflow
`else
    output logic              carry
`endif
);

    localparam int unsigned Msb = DATA_W - 1;

    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [2:0]        shamt;

    // Shift amounts come from the low three bits of x only.
    assign shamt = x[2:0];

    // Nine-bit adder paths; subtract is x + ~y + 1 so carry=1 means no borrow.
    always_comb begin
        sum_ext  = {1'b0, x} + {1'b0, y};
        diff_ext = {1'b0, x} + {1'b0, ~y} + (DATA_W + 1)'(1);
    end

    // Opcode decode for the result and carry flag.
    always_comb begin
        out   = '0;
        carry = 1'b0;
        case (ctrl)
            OP_ADD: begin
                out   = sum_ext[Msb:0];
                carry = sum_ext[DATA_W];
            end
            OP_SUB: begin
                out   = diff_ext[Msb:0];
                carry = diff_ext[DATA_W];
            end
            OP_AND:  out = x & y;
            OP_OR:   out = x | y;
            OP_NOT:  out = ~x;
            OP_XOR:  out = x ^ y;
            OP_NOR:  out = ~(x | y);
            OP_SLL:  out = y << shamt;
            OP_SRL:  out = y >> shamt;
            OP_SRA:  out = {x[Msb], x[Msb:1]};
            OP_ROL:  out = {x[Msb-1:0], x[Msb]};
            OP_ROR:  out = {x[0], x[Msb:1]};
            OP_EQ:   out = (x == y) ? DATA_W'(1) : '0;
            default: out = '0;
        endcase
    end

`ifdef SIMPLE_CALC_OVERFLOW_EN
    // Signed overflow: operands that should agree in sign produce a result of
    // the opposite sign (for subtract, y is effectively negated).
    always_comb begin
        overflow = 1'b0;
        if (ctrl == OP_ADD) begin
            overflow = (x[Msb] == y[Msb]) && (sum_ext[Msb] != x[Msb]);
        end else if (ctrl == OP_SUB) begin
            overflow = (x[Msb] != y[Msb]) && (diff_ext[Msb] != x[Msb]);
        end
    end
`endif

endmodule

// File: rtl/simple_calculator.sv
// Calculator datapath core: 2**ADDR_W x DATA_W register file (entry 0 reads
// as zero), two combinational read ports feeding calc_alu, and one write port
// that stores DataIn or the ALU result.
// Optional feature macro: SIMPLE_CALC_OVERFLOW_EN (adds the Overflow output).
module simple_calculator
    import simple_calculator_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] RW,
    input  logic [ADDR_W-1:0] RX,
    input  logic [ADDR_W-1:0] RY,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Sel,
    input  logic [CTRL_W-1:0] Ctrl,
    output logic [DATA_W-1:0] busY,
`ifdef SIMPLE_CALC_OVERFLOW_EN
    output logic              Carry,
    output logic              Overflow
`else
    output logic              Carry
`endif
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic [DATA_W-1:0] regs_d [NumRegs];
    logic [DATA_W-1:0] bus_x;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] wdata;

    // Read ports: no bypass, so a same-cycle write is seen only after the edge.
    always_comb begin
        bus_x = (RX == '0) ? '0 : regs_q[RX];
        busY  = (RY == '0) ? '0 : regs_q[RY];
    end

    calc_alu #(
        .DATA_W   (DATA_W)
    ) u_alu (
        .x        (bus_x),
        .y        (busY),
        .ctrl     (Ctrl),
        .out      (alu_out),
`ifdef SIMPLE_CALC_OVERFLOW_EN
        .carry    (Carry),
        .overflow (Overflow)
`else
        .carry    (Carry)
`endif
    );

    // Write-data select between the external bus and the ALU result.
    assign wdata = Sel ? alu_out : DataIn;

    // Next-state of the register file; address 0 is never written.
    always_comb begin
        regs_d = regs_q;
        if (WEN && (RW != '0)) begin
            regs_d[RW] = wdata;
        end
    end

    // Register file state; reset clears everything and blocks writes.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_simple_calculator.sv
// Self-checking bench for simple_calculator: directed scenarios from the lab
// flow plus randomized traffic, checked against an arithmetic reference model.
module tb_simple_calculator;

    logic       Clk;
    logic       Rst_n;
    logic       WEN;
    logic [2:0] RW;
    logic [2:0] RX;
    logic [2:0] RY;
    logic [7:0] DataIn;
    logic       Sel;
    logic [3:0] Ctrl;
    logic [7:0] busY;
    logic       Carry;
`ifdef SIMPLE_CALC_OVERFLOW_EN
    logic       Overflow;
`endif

    int total;
    int bad;

    // Reference register contents; entry 0 is never written.
    logic [7:0] mregs [8];

    simple_calculator dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .WEN      (WEN),
        .RW       (RW),
        .RX       (RX),
        .RY       (RY),
        .DataIn   (DataIn),
        .Sel      (Sel),
        .Ctrl     (Ctrl),
        .busY     (busY),
`ifdef SIMPLE_CALC_OVERFLOW_EN
        .Carry    (Carry),
        .Overflow (Overflow)
`else
        .Carry    (Carry)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference ALU from the opcode table using integer arithmetic.
    function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] x,
                                             input logic [7:0] y);
        int xi;
        int yi;
        int r;
        logic c;
        xi = int'(x);
        yi = int'(y);
        r  = 0;
        c  = 1'b0;
        case (op)
            4'd0: begin r = xi + yi; c = (r > 255); r = r % 256; end
            4'd1: begin r = (xi - yi + 256) % 256; c = (xi >= yi); end
            4'd2: r = int'(x & y);
            4'd3: r = int'(x | y);
            4'd4: r = 255 - xi;
            4'd5: r = int'(x ^ y);
            4'd6: r = 255 - int'(x | y);
            4'd7: r = (yi * (1 << (xi % 8))) % 256;
            4'd8: r = yi / (1 << (xi % 8));
            4'd9: r = xi / 2 + ((xi >= 128) ? 128 : 0);
            4'd10: r = (xi * 2) % 256 + xi / 128;
            4'd11: r = xi / 2 + (xi % 2) * 128;
            4'd12: r = (xi == yi) ? 1 : 0;
            default: r = 0;
        endcase
        return {c, 8'(r)};
    endfunction

    function automatic logic [7:0] mread(input logic [2:0] a);
        return (a == 3'd0) ? 8'h00 : mregs[a];
    endfunction

    // One clocked transaction; the model is updated with pre-edge values.
    task automatic do_write(input logic wen, input logic [2:0] rw, input logic sel,
                            input logic [7:0] data, input logic [3:0] op,
                            input logic [2:0] rx, input logic [2:0] ry);
        logic [8:0] res;
        WEN    = wen;
        RW     = rw;
        Sel    = sel;
        DataIn = data;
        Ctrl   = op;
        RX     = rx;
        RY     = ry;
        res    = alu_model(op, mread(rx), mread(ry));
        @(posedge Clk);
        #1;
        if (wen && rw != 3'd0) mregs[rw] = sel ? res[7:0] : data;
        WEN = 1'b0;
    endtask

    task automatic load(input logic [2:0] rw, input logic [7:0] data);
        do_write(1'b1, rw, 1'b0, data, 4'd0, 3'd0, 3'd0);
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry,
                          input logic [2:0] rw);
        do_write(1'b1, rw, 1'b1, 8'h00, op, rx, ry);
    endtask

    task automatic test_reset;
        Rst_n  = 1'b0;
        WEN    = 1'b0;
        RW     = 3'd0;
        RX     = 3'd0;
        RY     = 3'd0;
        DataIn = 8'h00;
        Sel    = 1'b0;
        Ctrl   = 4'd0;
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        #2;
        for (int i = 0; i < 8; i++) begin
            RY = 3'(i);
            #1;
            total++;
            if (busY !== 8'h00) begin
                bad++;
                $display("FAIL reset_busY[%0d]: got %h want 00", i, busY);
            end
        end
        total++;
        if (Carry !== 1'b0) begin
            bad++;
            $display("FAIL reset_carry: got %b want 0", Carry);
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_load_readback;
        load(3'd1, 8'b0000_0011);
        RY = 3'd1;
        #1;
        total++;
        if (busY !== 8'b0000_0011) begin
            bad++;
            $display("FAIL load_r1: got %b want 00000011", busY);
        end
        load(3'd2, 8'b0000_0101);
        RY = 3'd2;
        #1;
        total++;
        if (busY !== 8'b0000_0101) begin
            bad++;
            $display("FAIL load_r2: got %b want 00000101", busY);
        end
    endtask

    task automatic test_rotate_sra;
        alu_op(4'b1011, 3'd2, 3'd0, 3'd3);
        RY = 3'd3;
        #1;
        total++;
        if (busY !== 8'b1000_0010) begin
            bad++;
            $display("FAIL ror_r3: got %b want 10000010", busY);
        end
        // Read-modify-write in place: RX=RW=3.
        for (int i = 0; i < 7; i++) alu_op(4'b1001, 3'd3, 3'd0, 3'd3);
        RY = 3'd3;
        #1;
        total++;
        if (busY !== 8'b1111_1111) begin
            bad++;
            $display("FAIL sra_r3: got %b want 11111111", busY);
        end
    endtask

    task automatic test_multiply;
        load(3'd1, 8'd3);
        load(3'd2, 8'd5);
        // Mask i = bit i of B moved to the MSB, then sign-smeared by 7 SRAs.
        for (int i = 0; i < 4; i++) begin
            load(3'd7, 8'(7 - i));
            alu_op(4'b0111, 3'd7, 3'd2, 3'(3 + i));
            for (int k = 0; k < 7; k++) alu_op(4'b1001, 3'(3 + i), 3'd0, 3'(3 + i));
        end
        for (int i = 0; i < 4; i++) alu_op(4'b0010, 3'd1, 3'(3 + i), 3'(3 + i));
        for (int i = 1; i < 4; i++) begin
            for (int k = 0; k < i; k++) alu_op(4'b1010, 3'(3 + i), 3'd0, 3'(3 + i));
        end
        for (int i = 1; i < 4; i++) alu_op(4'b0000, 3'd3, 3'(3 + i), 3'd3);
        RX = 3'd3;
        RY = 3'd3;
        Ctrl = 4'b0000;
        #1;
        total++;
        if (busY !== 8'd15) begin
            bad++;
            $display("FAIL mul_result: got %0d want 15", busY);
        end
        total++;
        if (Carry !== 1'b0) begin
            bad++;
            $display("FAIL mul_carry: got %b want 0", Carry);
        end
    endtask

    task automatic test_carry;
        load(3'd1, 8'hFF);
        load(3'd2, 8'h01);
        RX = 3'd1;
        RY = 3'd2;
        Ctrl = 4'b0000;
        #1;
        total++;
        if (Carry !== 1'b1) begin
            bad++;
            $display("FAIL add_carry: got %b want 1", Carry);
        end
        alu_op(4'b0000, 3'd1, 3'd2, 3'd3);
        RY = 3'd3;
        #1;
        total++;
        if (busY !== 8'h00) begin
            bad++;
            $display("FAIL add_wrap: got %h want 00", busY);
        end
        load(3'd1, 8'h00);
        RX = 3'd1;
        RY = 3'd2;
        Ctrl = 4'b0001;
        #1;
        total++;
        if (Carry !== 1'b0) begin
            bad++;
            $display("FAIL sub_borrow: got %b want 0", Carry);
        end
        alu_op(4'b0001, 3'd1, 3'd2, 3'd4);
        RY = 3'd4;
        #1;
        total++;
        if (busY !== 8'hFF) begin
            bad++;
            $display("FAIL sub_wrap: got %h want ff", busY);
        end
    endtask

    task automatic test_reg0_reset;
        do_write(1'b1, 3'd0, 1'b0, 8'hAA, 4'd0, 3'd0, 3'd0);
        RY = 3'd0;
        #1;
        total++;
        if (busY !== 8'h00) begin
            bad++;
            $display("FAIL reg0_write: got %h want 00", busY);
        end
        load(3'd1, 8'h55);
        RY = 3'd1;
        #1;
        total++;
        if (busY !== 8'h55) begin
            bad++;
            $display("FAIL pre_reset_r1: got %h want 55", busY);
        end
        // Mid-cycle asynchronous reset, checked before the next rising edge.
        #2;
        Rst_n = 1'b0;
        #1;
        total++;
        if (busY !== 8'h00) begin
            bad++;
            $display("FAIL async_reset: got %h want 00", busY);
        end
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        WEN = 1'b1;
        RW = 3'd1;
        Sel = 1'b0;
        DataIn = 8'h77;
        @(posedge Clk);
        #1;
        total++;
        if (busY !== 8'h00) begin
            bad++;
            $display("FAIL write_in_reset: got %h want 00", busY);
        end
        WEN = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_equality;
        load(3'd1, 8'h3C);
        load(3'd2, 8'h3C);
        alu_op(4'b1100, 3'd1, 3'd2, 3'd3);
        RY = 3'd3;
        #1;
        total++;
        if (busY !== 8'h01) begin
            bad++;
            $display("FAIL eq_true: got %h want 01", busY);
        end
        RX = 3'd1;
        RY = 3'd2;
        Ctrl = 4'b1111;
        #1;
        total++;
        if (Carry !== 1'b0) begin
            bad++;
            $display("FAIL default_carry: got %b want 0", Carry);
        end
        alu_op(4'b1111, 3'd1, 3'd2, 3'd4);
        RY = 3'd4;
        #1;
        total++;
        if (busY !== 8'h00) begin
            bad++;
            $display("FAIL default_out: got %h want 00", busY);
        end
    endtask

    task automatic test_random;
        logic [8:0] res;
        for (int i = 1; i < 8; i++) load(3'(i), 8'($urandom));
        for (int n = 0; n < 300; n++) begin
            WEN    = ($urandom_range(0, 3) != 0);
            RW     = 3'($urandom);
            Sel    = 1'($urandom);
            DataIn = 8'($urandom);
            Ctrl   = 4'($urandom);
            RX     = 3'($urandom);
            RY     = 3'($urandom);
            #1;
            res = alu_model(Ctrl, mread(RX), mread(RY));
            total++;
            if (Carry !== res[8] || busY !== mread(RY)) begin
                bad++;
                $display("FAIL rand_comb[%0d]: op=%h carry=%b busY=%h want carry=%b busY=%h",
                         n, Ctrl, Carry, busY, res[8], mread(RY));
            end
            do_write(WEN, RW, Sel, DataIn, Ctrl, RX, RY);
        end
        for (int i = 0; i < 8; i++) begin
            RY = 3'(i);
            #1;
            total++;
            if (busY !== mread(3'(i))) begin
                bad++;
                $display("FAIL rand_final[%0d]: got %h want %h", i, busY, mread(3'(i)));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_load_readback();
        test_rotate_sra();
        test_multiply();
        test_carry();
        test_reg0_reset();
        test_equality();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simple_calculator.md
Name: simple_calculator

Overview:
- 8-entry × 8-bit register file coupled to a combinational 8-bit ALU; this is the datapath core of the lab calculator.
- Two combinational read ports: busX is addressed by RX and busY by RY. busX and busY are the ALU operands x and y.
- One synchronous write port, addressed by RW. It stores either external DataIn or the ALU result, chosen by Sel.
- busY is brought out as the observation bus; Carry reports the adder carry-out.

Parameters:
- DATA_W, 8, datapath width (x, y, DataIn, busY, ALU result).
- ADDR_W, 3, register address width; the file has 2**ADDR_W entries.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- WEN  input  1  register write enable.
- RW  input  ADDR_W  write address.
- RX  input  ADDR_W  read address for operand x (internal busX).
- RY  input  ADDR_W  read address for operand y; also drives busY.
- DataIn  input  DATA_W  external write data.
- Sel  input  1  write-data select: 0 = DataIn, 1 = ALU result.
- Ctrl  input  4  ALU opcode.
- busY  output  DATA_W  register[RY], combinational.
- Carry  output  1  ALU carry flag, combinational.

Behaviour:
- Register 0 is hardwired to 8'h00. Writes to address 0 are ignored, and reads of address 0 return 0.
- Write: on the rising edge of Clk, if WEN=1 and RW≠0, reg[RW] <= (Sel ? alu_out : DataIn).
- Read ports are purely combinational with no bypass. A value written at an edge is visible on busX/busY after that edge; zero read latency.
- Reading and writing the same register in one cycle is legal. The ALU sees the old value, and the new value lands at the edge (read-modify-write such as RX=RW=3).
- Reset: Rst_n=0 immediately clears registers 1..7 to 0, independent of Clk. busY therefore reads 0. Writes are blocked while reset is asserted.
- ALU, with x=busX and y=busY:
  - 0000: {Carry,out} = x + y (9-bit unsigned sum).
  - 0001: out = x − y. Carry = carry-out of x + ~y + 1, so 1 means no borrow.
  - 0010: x & y. 0011: x | y. 0100: ~x. 0101: x ^ y. 0110: ~(x | y).
  - 0111: y << x[2:0], logical. 1000: y >> x[2:0], logical.
  - 1001: arithmetic right shift of x by 1, MSB replicated.
  - 1010: rotate x left by 1. 1011: rotate x right by 1.
  - 1100: out = (x == y) ? 8'h01 : 8'h00.
  - Codes 1101–1111: out = 0.
- Carry is 0 for every opcode other than 0000 and 0001.
- Add and subtract wrap modulo 256.

Optional Feature:
- Macro: SIMPLE_CALC_OVERFLOW_EN.
- When defined, an extra output port Overflow (1 bit) is added. It is the two's-complement signed overflow for opcodes 0000 and 0001 (operand signs vs result sign), and 0 for every other opcode.
- When not defined, the port does not exist and all other behaviour is identical.

Decomposition:
- Shared package holds:
  - the Ctrl opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR, OP_EQ);
  - the DATA_W and ADDR_W defaults.
- One sub-module: calc_alu, purely combinational, with inputs x, y, ctrl and outputs out, carry (and overflow under the macro).
- The register file and write mux stay inline in simple_calculator.

Test Plan:
- Load and readback: Sel=0, WEN=1, RW=1, DataIn=8'b00000011, one edge; then WEN=0, RY=1 → busY=00000011. Repeat with RW=2, DataIn=00000101 → busY=00000101.
- Rotate and SRA mask: reg2=00000101; Ctrl=1011, Sel=1, RX=2, RW=3 → reg3=10000010. Then 7 edges of Ctrl=1001 with RX=RW=3 → reg3=11111111.
- AND/shift/add multiply flow:
  - build masks of B=5 bits 0..3 in reg3..reg6;
  - AND each mask with A=3;
  - rotate-left the reg4/5/6 partial products 1/2/3 times;
  - accumulate with Ctrl=0000 into reg3;
  - result: RY=3 → busY=15 (00001111), Carry=0.
- Carry: reg1=8'hFF, reg2=8'h01, Ctrl=0000, RX=1, RY=2 → ALU result 0, Carry=1. Ctrl=0001 with reg1=0, reg2=1 → result 8'hFF, Carry=0.
- Register 0 and reset:
  - WEN=1, RW=0, DataIn=8'hAA, then RY=0 → busY=0.
  - Assert Rst_n=0 mid-cycle after loading reg1=8'h55 → busY(RY=1)=0 before the next Clk edge.
- Equality and default: reg1=reg2=8'h3C, Ctrl=1100 → result 8'h01; Ctrl=1111 → result 0, Carry=0.
